left_shift_ser_ctrl: RTL and testbench

Sequencing controller for the left-shift register datapath. It accepts parallel words over a valid/ready handshake, loads each word into an internal DW-bit left-shift register, and shifts it out MSB-first with frame markers. It can stall on request and inserts a programmable idle gap between frames. It sits between a word producer and a serial consumer, and replaces ad-hoc load/en sequencing of the bare shift register.

---
 rtl/left_shift_ser_ctrl.sv | 179 +++++++++++++++++
 tb/tb_left_shift_ser_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/left_shift_ser_ctrl.sv
// left_shift_ser_ctrl
//   Sequencing controller around a DW-bit left-shift register. Accepts words
//   over valid/ready, shifts them out MSB-first with sof/eof frame markers,
//   honours a stall request and inserts GAP idle cycles between frames.
//
//   Optional feature macro: SHIFT_CTRL_PARITY_EN
//     When defined, an even-parity bit is appended after the data bits and
//     eof moves onto it.
//
// Parameters
//   DW   word width (>= 2)
//   GAP  idle cycles after each frame (0..15)
//
// Ports
//   clk          rising-edge clock
//   async_rst_n  asynchronous active-low reset
//   in_valid     producer offers in_data
//   in_ready     controller accepts a word this cycle
//   in_data      parallel word to serialize
//   fill_bit     bit shifted into the LSB on every shift
//   stall        freezes shifting while high
//   ser_out      current serial bit
//   ser_valid    ser_out carries a frame bit this cycle
//   sof / eof    first / last bit of the frame
//   q            shift register contents
//   busy         controller is not idle
module left_shift_ser_ctrl #(
    parameter int DW  = 4,
    parameter int GAP = 1
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          fill_bit,
    input  logic          stall,
    output logic          ser_out,
    output logic          ser_valid,
    output logic          sof,
    output logic          eof,
    output logic [DW-1:0] q,
    output logic          busy
);

    localparam int            CW       = $clog2(DW) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);
    localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
`ifdef SHIFT_CTRL_PARITY_EN
        S_PARITY = 2'd3,
`endif
        S_GAP    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] bit_cnt;
    logic [3:0]    gap_cnt;
    logic          load;
    logic          shift_en;
    logic          gap_start;
    logic          final_bit;
`ifdef SHIFT_CTRL_PARITY_EN
    logic          par_reg;
`endif

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        gap_start  = 1'b0;
        final_bit  = 1'b0;
        in_ready   = 1'b0;
        ser_out    = 1'b0;
        ser_valid  = 1'b0;
        sof        = 1'b0;
        eof        = 1'b0;

        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                ser_out   = q[DW-1];
                ser_valid = !stall;
                sof       = !stall && (bit_cnt == '0);
                shift_en  = !stall;
                if (!stall && (bit_cnt == LAST_BIT)) begin
`ifdef SHIFT_CTRL_PARITY_EN
                    state_next = S_PARITY;
`else
                    final_bit = 1'b1;
                    eof       = 1'b1;
`endif
                end
            end
`ifdef SHIFT_CTRL_PARITY_EN
            S_PARITY: begin
                ser_out   = par_reg;
                ser_valid = !stall;
                if (!stall) begin
                    final_bit = 1'b1;
                    eof       = 1'b1;
                end
            end
`endif
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Final bit retiring: either enter the gap or, with no gap, open
        // in_ready so the next word loads on the same edge.
        if (final_bit) begin
            if (GAP > 0) begin
                state_next = S_GAP;
                gap_start  = 1'b1;
            end else begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = S_SHIFT;
                end else begin
                    state_next = S_IDLE;
                end
            end
        end
    end

    // A back-to-back load coincides with the final shift; the load wins.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            q       <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
`ifdef SHIFT_CTRL_PARITY_EN
            par_reg <= 1'b0;
`endif
        end else begin
            if (load) begin
                q       <= in_data;
                bit_cnt <= '0;
`ifdef SHIFT_CTRL_PARITY_EN
                par_reg <= ^in_data;
`endif
            end else if (shift_en) begin
                q       <= {q[DW-2:0], fill_bit};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (gap_start) begin
                gap_cnt <= '0;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_left_shift_ser_ctrl.sv
// Testbench for left_shift_ser_ctrl: table-driven per-cycle vectors on a
// DW=4/GAP=1 instance plus hand sequences for back-to-back frames on a
// GAP=0 instance and an asynchronous reset in mid-frame.
module tb_left_shift_ser_ctrl;

`ifdef SHIFT_CTRL_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_valid = 1'b0, a_fill = 1'b0, a_stall = 1'b0;
    logic [3:0] a_data = '0;
    logic       a_ready, a_so, a_sv, a_sof, a_eof, a_busy;
    logic [3:0] a_q;

    logic       b_valid = 1'b0, b_fill = 1'b0, b_stall = 1'b0;
    logic [3:0] b_data = '0;
    logic       b_ready, b_so, b_sv, b_sof, b_eof, b_busy;
    logic [3:0] b_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    left_shift_ser_ctrl #(.DW(4), .GAP(1)) dut_a (
        .clk(clk), .async_rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .fill_bit(a_fill), .stall(a_stall), .ser_out(a_so),
        .ser_valid(a_sv), .sof(a_sof), .eof(a_eof), .q(a_q), .busy(a_busy)
    );

    left_shift_ser_ctrl #(.DW(4), .GAP(0)) dut_b (
        .clk(clk), .async_rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .fill_bit(b_fill), .stall(b_stall), .ser_out(b_so),
        .ser_valid(b_sv), .sof(b_sof), .eof(b_eof), .q(b_q), .busy(b_busy)
    );

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       f;
        logic       s;
        logic       so;
        logic       sv;
        logic       sf;
        logic       ef;
        logic [3:0] q;
        logic       rdy;
        logic       bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic void row(input logic v, input logic [3:0] d, input logic f,
                                input logic s, input logic so, input logic sv,
                                input logic sf, input logic ef, input logic [3:0] qq,
                                input logic rdy, input logic bsy);
        vec_t r;
        r.v = v; r.d = d; r.f = f; r.s = s; r.so = so; r.sv = sv;
        r.sf = sf; r.ef = ef; r.q = qq; r.rdy = rdy; r.bsy = bsy;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [9:0] seq_bits;
    logic [3:0] w;

    initial begin
        // ---- reset state ----
        #7;
        chk("rst_q", 8'(a_q), 8'h0);
        chk("rst_sv", 8'(a_sv), 8'h0);
        chk("rst_ready", 8'(a_ready), 8'h1);
        chk("rst_busy", 8'(a_busy), 8'h0);
        chk("rst_eof", 8'(a_eof), 8'h0);
        chk("rst_so", 8'(a_so), 8'h0);
        rst_n = 1'b1;
        tick();

        // ---- frame 1: 1011, fill 0 ----
        row(1, 4'b1011, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0);
        row(0, 4'b0000, 0, 0, 1, 1, 1, 0, 4'b1011, 0, 1);
        row(0, 4'b0000, 0, 0, 0, 1, 0, 0, 4'b0110, 0, 1);
        row(0, 4'b0000, 0, 0, 1, 1, 0, 0, 4'b1100, 0, 1);
`ifdef SHIFT_CTRL_PARITY_EN
        row(0, 4'b0000, 0, 0, 1, 1, 0, 0, 4'b1000, 0, 1);
        row(0, 4'b0000, 0, 0, 1, 1, 0, 1, 4'b0000, 0, 1);
`else
        row(0, 4'b0000, 0, 0, 1, 1, 0, 1, 4'b1000, 0, 1);
`endif
        row(1, 4'b0110, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1); // gap: valid ignored
        // ---- frame 2: 0000, fill 1 (stall in idle has no effect) ----
        row(1, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0000, 1, 0);
        row(0, 4'b0000, 1, 0, 0, 1, 1, 0, 4'b0000, 0, 1);
        row(0, 4'b0000, 1, 0, 0, 1, 0, 0, 4'b0001, 0, 1);
        row(0, 4'b0000, 1, 0, 0, 1, 0, 0, 4'b0011, 0, 1);
`ifdef SHIFT_CTRL_PARITY_EN
        row(0, 4'b0000, 1, 0, 0, 1, 0, 0, 4'b0111, 0, 1);
        row(0, 4'b0000, 1, 0, 0, 1, 0, 1, 4'b1111, 0, 1);
`else
        row(0, 4'b0000, 1, 0, 0, 1, 0, 1, 4'b0111, 0, 1);
`endif
        row(0, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b1111, 0, 1);
        // ---- frame 3: 1010, stall 3 cycles after bit 2 ----
        row(1, 4'b1010, 0, 0, 0, 0, 0, 0, 4'b1111, 1, 0);
        row(0, 4'b0000, 0, 0, 1, 1, 1, 0, 4'b1010, 0, 1);
        row(0, 4'b0000, 0, 0, 0, 1, 0, 0, 4'b0100, 0, 1);
        row(0, 4'b0000, 1, 1, 1, 0, 0, 0, 4'b1000, 0, 1);
        row(0, 4'b0000, 1, 1, 1, 0, 0, 0, 4'b1000, 0, 1);
        row(0, 4'b0000, 1, 1, 1, 0, 0, 0, 4'b1000, 0, 1);
        row(0, 4'b0000, 0, 0, 1, 1, 0, 0, 4'b1000, 0, 1);
`ifdef SHIFT_CTRL_PARITY_EN
        row(0, 4'b0000, 0, 0, 0, 1, 0, 0, 4'b0000, 0, 1);
        row(0, 4'b0000, 0, 0, 0, 1, 0, 1, 4'b0000, 0, 1);
`else
        row(0, 4'b0000, 0, 0, 0, 1, 0, 1, 4'b0000, 0, 1);
`endif
        row(0, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1);
        // ---- frame 4: 1001, stall on the final bit ----
        row(1, 4'b1001, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0);
        row(0, 4'b0000, 0, 0, 1, 1, 1, 0, 4'b1001, 0, 1);
        row(0, 4'b0000, 0, 0, 0, 1, 0, 0, 4'b0010, 0, 1);
        row(0, 4'b0000, 0, 0, 0, 1, 0, 0, 4'b0100, 0, 1);
`ifdef SHIFT_CTRL_PARITY_EN
        row(0, 4'b0000, 0, 0, 1, 1, 0, 0, 4'b1000, 0, 1);
        row(0, 4'b0000, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 1);
        row(0, 4'b0000, 0, 0, 0, 1, 0, 1, 4'b0000, 0, 1);
`else
        row(0, 4'b0000, 0, 1, 1, 0, 0, 0, 4'b1000, 0, 1);
        row(0, 4'b0000, 0, 0, 1, 1, 0, 1, 4'b1000, 0, 1);
`endif
        row(0, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1);
        row(0, 4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0);

        foreach (tbl[i]) begin
            a_valid = tbl[i].v; a_data = tbl[i].d;
            a_fill  = tbl[i].f; a_stall = tbl[i].s;
            #1;
            chk($sformatf("row%0d_so", i),    8'(a_so),    8'(tbl[i].so));
            chk($sformatf("row%0d_sv", i),    8'(a_sv),    8'(tbl[i].sv));
            chk($sformatf("row%0d_sof", i),   8'(a_sof),   8'(tbl[i].sf));
            chk($sformatf("row%0d_eof", i),   8'(a_eof),   8'(tbl[i].ef));
            chk($sformatf("row%0d_q", i),     8'(a_q),     8'(tbl[i].q));
            chk($sformatf("row%0d_ready", i), 8'(a_ready), 8'(tbl[i].rdy));
            chk($sformatf("row%0d_busy", i),  8'(a_busy),  8'(tbl[i].bsy));
            tick();
        end
        a_valid = 1'b0; a_stall = 1'b0; a_fill = 1'b0;

        // ---- GAP=0 back-to-back: 1100 then 0011 held valid ----
`ifdef SHIFT_CTRL_PARITY_EN
        seq_bits = 10'b11000_00110;
`else
        seq_bits = 10'b00_11000011;
`endif
        b_valid = 1'b1; b_data = 4'b1100;
        #1 chk("b2b_ready_idle", 8'(b_ready), 8'h1);
        tick();
        b_data = 4'b0011;
        for (int i = 0; i < 2 * FL; i++) begin
            #1;
            chk($sformatf("b2b%0d_so", i),  8'(b_so),  8'(seq_bits[2*FL-1-i]));
            chk($sformatf("b2b%0d_sv", i),  8'(b_sv),  8'h1);
            chk($sformatf("b2b%0d_sof", i), 8'(b_sof), 8'((i % FL) == 0));
            chk($sformatf("b2b%0d_eof", i), 8'(b_eof), 8'((i % FL) == FL - 1));
            chk($sformatf("b2b%0d_rdy", i), 8'(b_ready), 8'((i % FL) == FL - 1));
            tick();
            if (i == FL - 1) b_valid = 1'b0;
        end
        #1;
        chk("b2b_end_sv", 8'(b_sv), 8'h0);
        chk("b2b_end_busy", 8'(b_busy), 8'h0);
        tick();

        // ---- GAP=0: stall on final bit holds in_ready low ----
        b_valid = 1'b1; b_data = 4'b1000;
        tick();
        b_data = 4'b1111;
        for (int i = 0; i < FL - 1; i++) tick();
        b_stall = 1'b1;
        #1;
        chk("fstall_ready", 8'(b_ready), 8'h0);
        chk("fstall_eof", 8'(b_eof), 8'h0);
        tick();
        b_stall = 1'b0; b_valid = 1'b0;
        #1;
        chk("fstall_rel_ready", 8'(b_ready), 8'h1);
        chk("fstall_rel_eof", 8'(b_eof), 8'h1);
        tick();
        #1 chk("fstall_idle_busy", 8'(b_busy), 8'h0);
        tick();

        // ---- async reset mid-frame ----
        a_valid = 1'b1; a_data = 4'b1011;
        tick();
        a_valid = 1'b0;
        tick();
        tick();                      // two bits out, now on bit 3
        #1 chk("pre_rst_busy", 8'(a_busy), 8'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_q", 8'(a_q), 8'h0);
        chk("arst_sv", 8'(a_sv), 8'h0);
        chk("arst_ready", 8'(a_ready), 8'h1);
        chk("arst_eof", 8'(a_eof), 8'h0);
        chk("arst_busy", 8'(a_busy), 8'h0);
        #1 rst_n = 1'b1;
        tick();
        w = 4'b0110;
        a_valid = 1'b1; a_data = w;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            #1;
            chk($sformatf("post%0d_so", i), 8'(a_so), 8'((i < 4) ? w[3-i] : ^w));
            chk($sformatf("post%0d_sv", i), 8'(a_sv), 8'h1);
            chk($sformatf("post%0d_eof", i), 8'(a_eof), 8'(i == FL - 1));
            tick();
        end
        #1 chk("post_gap_sv", 8'(a_sv), 8'h0);
        tick();
        #1 chk("post_idle_ready", 8'(a_ready), 8'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
